matmul_seq: RTL

MATMUL_SEQ -- requirements
Module: matmul_seq

---
 rtl/matmul_seq_if.sv | 34 +++
 rtl/matmul_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/matmul_seq_if.sv
// Handshake and register-file read bus for the sequential 4x4 matrix multiplier.
// The slave modport is the multiplier; the master side is loader plus result consumer.
interface matmul_seq_if #(
  parameter int DW = 8,
  parameter int RW = 2*DW+2
);
  logic          start;
  logic          busy;
  logic          done;
  logic [4:0]    rd_addr_1;
  logic [4:0]    rd_addr_2;
  logic [4:0]    rd_addr_3;
  logic [4:0]    rd_addr_4;
  logic [DW-1:0] rd_data_1;
  logic [DW-1:0] rd_data_2;
  logic [DW-1:0] rd_data_3;
  logic [DW-1:0] rd_data_4;
  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] res_data;
  logic [3:0]    res_idx;

  modport slave (
    input  start, rd_data_1, rd_data_2, rd_data_3, rd_data_4, res_ready,
    output busy, done, rd_addr_1, rd_addr_2, rd_addr_3, rd_addr_4,
           res_valid, res_data, res_idx
  );

  modport master (
    output start, rd_data_1, rd_data_2, rd_data_3, rd_data_4, res_ready,
    input  busy, done, rd_addr_1, rd_addr_2, rd_addr_3, rd_addr_4,
           res_valid, res_data, res_idx
  );
endinterface

// File: rtl/matmul_seq.sv
// Sequential 4x4 unsigned matrix multiply: two products per cycle, one C element
// every two cycles, results delivered through a valid/ready output register.
module matmul_seq #(
  parameter int DW = 8,
  parameter int RW = 2*DW+2
) (
  input  logic         clk,
  input  logic         rst_n,
  matmul_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [3:0]    elem_q, elem_d;
  logic          phase_q, phase_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [RW-1:0] res_data_q, res_data_d;
  logic [3:0]    res_idx_q, res_idx_d;
  logic          res_valid_q, res_valid_d;
  logic          done_q, done_d;

  logic [1:0]    row, col;
  logic [RW-1:0] d1, d2, d3, d4, pair_sum;
  logic [4:0]    a1, a2, a3, a4;
  logic          accept;

  assign row = elem_q[3:2];
  assign col = elem_q[1:0];

  // Widen before multiplying so the products are not truncated to DW bits.
  assign d1 = RW'(bus.rd_data_1);
  assign d2 = RW'(bus.rd_data_2);
  assign d3 = RW'(bus.rd_data_3);
  assign d4 = RW'(bus.rd_data_4);
  assign pair_sum = d1 * d2 + d3 * d4;

  assign accept = res_valid_q && bus.res_ready;

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    phase_d     = phase_q;
    acc_d       = acc_q;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;
    res_valid_d = res_valid_q;
    done_d      = 1'b0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    a4 = '0;

    if (accept) res_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // start on the done cycle is dropped as well
        if (bus.start && !done_q) begin
          state_d = RUN;
          elem_d  = '0;
          phase_d = 1'b0;
          acc_d   = '0;
        end
      end
      RUN: begin
        // phase selects k = {0,1} or {2,3}; A row block at 0, B at 16
        a1 = {1'b0, row, phase_q, 1'b0};
        a2 = {1'b1, phase_q, 1'b0, col};
        a3 = {1'b0, row, phase_q, 1'b1};
        a4 = {1'b1, phase_q, 1'b1, col};
        if (!phase_q) begin
          acc_d   = pair_sum;
          phase_d = 1'b1;
        end else if (!res_valid_q || bus.res_ready) begin
          res_data_d  = acc_q + pair_sum;
          res_idx_d   = elem_q;
          res_valid_d = 1'b1;
          phase_d     = 1'b0;
          elem_d      = elem_q + 4'd1;
          if (elem_q == 4'd15) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (accept) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      elem_q      <= '0;
      phase_q     <= 1'b0;
      acc_q       <= '0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_idx   = res_idx_q;
  assign bus.rd_addr_1 = a1;
  assign bus.rd_addr_2 = a2;
  assign bus.rd_addr_3 = a3;
  assign bus.rd_addr_4 = a4;

endmodule
